// File: rtl/digit_column_sequencer_if.sv
// Column stream between the digit sequencer and the matrix column sink.
// The sequencer drives data/address/valid, the sink returns ready.
interface digit_column_sequencer_if;
  logic [31:0] col_data;
  logic [4:0]  col_addr;
  logic        col_valid;
  logic        col_ready;

  modport master (output col_data, col_addr, col_valid, input col_ready);
  modport slave  (input col_data, col_addr, col_valid, output col_ready);
endinterface

// File: rtl/digit_column_sequencer.sv
// Digit column sequencer: walks a frame of BCD digits six glyph columns at a
// time through an external glyph generator, then pads the frame with blank
// columns, streaming everything over a valid/ready column interface.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (never the last digit) emit blank columns
//   undefined -> every digit is rendered from the generator
//
// state | meaning
// IDLE  | waiting for start, outputs parked
// EMIT  | streaming glyph columns, digit d / column c
// PAD   | streaming zero columns up to MATRIX_COLS-1, then draining
// DONE  | one-cycle completion pulse
module digit_column_sequencer #(
  parameter int NUM_DIGITS  = 5,
  parameter int MATRIX_COLS = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [2:0]              color,
  output logic [3:0]              num,
  output logic [2:0]              numcol_index,
  output logic [2:0]              num_color,
  input  logic [31:0]             gen_col,
  digit_column_sequencer_if.master col_if,
  output logic                    busy,
  output logic                    done
);

  localparam int DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW         = $clog2(MATRIX_COLS + 1);
  localparam int GLYPH_COLS = NUM_DIGITS * 6;
  localparam logic [CW-1:0] GLYPH_END = CW'(GLYPH_COLS);
  localparam logic [CW-1:0] FRAME_END = CW'(MATRIX_COLS);

  typedef enum logic [1:0] {IDLE, EMIT, PAD, DONE} state_t;

  state_t                  state, state_n;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [2:0]              color_q;
  logic [DW-1:0]           d_cnt;
  logic [2:0]              c_cnt;
  logic [CW-1:0]           col_cnt;
  logic [31:0]             col_data_q;
  logic [4:0]              col_addr_q;
  logic                    col_valid_q;
  logic [3:0]              digit_cur;
  logic [31:0]             glyph_src;
  logic                    load_ok, last_glyph;
  logic                    latch, load_glyph, load_pad, drop;

  assign col_if.col_data  = col_data_q;
  assign col_if.col_addr  = col_addr_q;
  assign col_if.col_valid = col_valid_q;
  assign num_color        = color_q;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign load_ok          = !col_valid_q || col_if.col_ready;
  assign last_glyph       = (d_cnt == DW'(NUM_DIGITS - 1)) && (c_cnt == 3'd5);

  // select the latched digit addressed by the digit counter (digit 0 = MS nibble)
  always_comb begin
    digit_cur = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (d_cnt == DW'(i)) digit_cur = digits_q[4*(NUM_DIGITS-1-i) +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  blank_cur;

  // digit i is a leading zero when it and every digit left of it are zero;
  // the last digit is never blanked so a value of 0 still shows one glyph
  always_comb begin
    lead_zero = '0;
    blank_cur = 1'b0;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      lead_zero[i] = ((digits_q >> (4*(NUM_DIGITS-1-i))) == '0);
      if (d_cnt == DW'(i)) blank_cur = lead_zero[i];
    end
  end

  assign glyph_src = blank_cur ? 32'd0 : gen_col;
`else
  assign glyph_src = gen_col;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // next-state, datapath strobes and generator drive
  always_comb begin
    state_n      = state;
    latch        = 1'b0;
    load_glyph   = 1'b0;
    load_pad     = 1'b0;
    drop         = 1'b0;
    num          = '0;
    numcol_index = '0;
    case (state)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        num          = digit_cur;
        numcol_index = c_cnt;
        if (load_ok) begin
          // only reachable when glyphs fill the whole frame: drain the last beat
          if (col_cnt == GLYPH_END) begin
            drop    = 1'b1;
            state_n = DONE;
          end else begin
            load_glyph = 1'b1;
            if (last_glyph && (GLYPH_COLS != MATRIX_COLS)) state_n = PAD;
          end
        end
      end
      PAD: begin
        if (load_ok) begin
          if (col_cnt == FRAME_END) begin
            drop    = 1'b1;
            state_n = DONE;
          end else begin
            load_pad = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // frame latches, column counters and the registered column output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q    <= '0;
      color_q     <= '0;
      d_cnt       <= '0;
      c_cnt       <= '0;
      col_cnt     <= '0;
      col_data_q  <= '0;
      col_addr_q  <= '0;
      col_valid_q <= 1'b0;
    end else begin
      if (latch) begin
        digits_q <= digits;
        color_q  <= color;
        d_cnt    <= '0;
        c_cnt    <= '0;
        col_cnt  <= '0;
      end
      if (load_glyph) begin
        col_data_q  <= glyph_src;
        col_addr_q  <= 5'(col_cnt);
        col_valid_q <= 1'b1;
        col_cnt     <= col_cnt + 1'b1;
        if (c_cnt == 3'd5) begin
          c_cnt <= '0;
          d_cnt <= last_glyph ? '0 : d_cnt + 1'b1;
        end else begin
          c_cnt <= c_cnt + 3'd1;
        end
      end
      if (load_pad) begin
        col_data_q  <= '0;
        col_addr_q  <= 5'(col_cnt);
        col_valid_q <= 1'b1;
        col_cnt     <= col_cnt + 1'b1;
      end
      if (drop) col_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_digit_column_sequencer.sv
// Randomised self-checking bench for digit_column_sequencer. A behavioural
// glyph generator feeds the DUT; expected beats come from a frame model.
module tb_digit_column_sequencer;

  localparam int N    = 5;
  localparam int COLS = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [19:0]   digits;
  logic [2:0]    color;
  logic [3:0]    num;
  logic [2:0]    numcol_index;
  logic [2:0]    num_color;
  logic [31:0]   gen_col;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  digit_column_sequencer_if col_if ();

  digit_column_sequencer #(.NUM_DIGITS(N), .MATRIX_COLS(COLS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .digits       (digits),
    .color        (color),
    .num          (num),
    .numcol_index (numcol_index),
    .num_color    (num_color),
    .gen_col      (gen_col),
    .col_if       (col_if),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // behavioural glyph generator: distinct, never-zero word per (digit, column, colour)
  function automatic logic [31:0] gen_fn(input logic [3:0] n, input logic [2:0] i,
                                         input logic [2:0] colr);
    return {4'hA, colr, 1'b1, n, 1'b0, i, n ^ {1'b0, i}, 4'h5, ~n, {1'b0, i} + 4'd3};
  endfunction

  assign gen_col = gen_fn(num, numcol_index, num_color);

  // expected column k of a frame, from the digit value and place arithmetic
  function automatic logic [31:0] model_beat(input logic [19:0] dg, input logic [2:0] co,
                                             input int k);
    int          d, c;
    logic [31:0] v, place;
    logic [3:0]  nib;
    if (k >= N * 6) return 32'd0;
    d     = k / 6;
    c     = k % 6;
    v     = {12'd0, dg};
    place = 32'd1 << (4 * (N - 1 - d));
    nib   = 4'((v / place) % 16);
`ifdef LEADING_ZERO_BLANK_EN
    if (d != N - 1 && v < place) return 32'd0;
`endif
    return gen_fn(nib, 3'(c), co);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // mode: 0 ready always high, 1 random ready, 2 ready pattern 1,0,0,1
  task automatic run_frame(input logic [19:0] dg, input logic [2:0] co, input int mode,
                           input int start_at, input int rst_at);
    logic [31:0] exp_q[$];
    int          beats = 0, cycles = 0, last_hs = -10;
    bit          finished = 0, stall = 0, injected = 0;
    logic [31:0] p_data;
    logic [4:0]  p_addr;
    logic [3:0]  p_num;
    logic [2:0]  p_idx;
    for (int k = 0; k < COLS; k++) exp_q.push_back(model_beat(dg, co, k));
    p_data = '0; p_addr = '0; p_num = '0; p_idx = '0;
    @(negedge clk);
    digits = dg; color = co; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!finished && cycles < 400) begin
      start = 1'b0;
      if (mode == 0)      col_if.col_ready = 1'b1;
      else if (mode == 1) col_if.col_ready = ($urandom_range(0, 3) != 0);
      else                col_if.col_ready = ((cycles % 4) == 0) || ((cycles % 4) == 3);
      if (cycles == 0) chk("first_valid_low", 32'(col_if.col_valid), 32'd0);
      if (cycles == 1) chk("first_valid_high", 32'(col_if.col_valid), 32'd1);
      if (stall && col_if.col_valid) begin
        chk("stall_data", col_if.col_data, p_data);
        chk("stall_addr", 32'(col_if.col_addr), 32'(p_addr));
        chk("stall_num", 32'(num), 32'(p_num));
        chk("stall_idx", 32'(numcol_index), 32'(p_idx));
      end
      if (rst_at >= 0 && beats == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(col_if.col_valid), 32'd0);
        chk("rst_addr", 32'(col_if.col_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_color", 32'(num_color), 32'd0);
        @(negedge clk);
        chk("rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle_done", 32'(done), 32'd0);
        finished = 1;
      end else if (done) begin
        chk("done_beats", 32'(beats), 32'(COLS));
        chk("done_timing", 32'(cycles), 32'(last_hs + 1));
        chk("done_num", 32'(num), 32'd0);
        chk("done_idx", 32'(numcol_index), 32'd0);
        chk("done_valid", 32'(col_if.col_valid), 32'd0);
        chk("done_color", 32'(num_color), 32'(co));
        @(negedge clk);
        chk("done_pulse_len", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        finished = 1;
      end else begin
        if (col_if.col_valid && col_if.col_ready) begin
          if (beats < COLS) begin
            chk($sformatf("addr[%0d]", beats), 32'(col_if.col_addr), 32'(beats));
            chk($sformatf("data[%0d]", beats), col_if.col_data, exp_q[beats]);
          end else begin
            chk("extra_beat", 32'(beats), 32'(COLS - 1));
          end
          beats++;
          last_hs = cycles;
        end
        if (start_at >= 0 && !injected && beats == start_at) begin
          digits = 20'h99999; start = 1'b1; injected = 1;
        end
        stall  = col_if.col_valid && !col_if.col_ready;
        p_data = col_if.col_data;
        p_addr = col_if.col_addr;
        p_num  = num;
        p_idx  = numcol_index;
        @(negedge clk);
        cycles++;
      end
    end
    chk("frame_completed", 32'(finished), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; digits = '0; color = '0; col_if.col_ready = 1'b0;
    #3;
    chk("reset_valid", 32'(col_if.col_valid), 32'd0);
    chk("reset_data", col_if.col_data, 32'd0);
    chk("reset_addr", 32'(col_if.col_addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_color", 32'(num_color), 32'd0);
    chk("reset_num", 32'(num), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(20'h01234, 3'b010, 0, -1, -1);
    run_frame(20'h01234, 3'b010, 2, -1, -1);
    run_frame(20'h00007, 3'b100, 1, -1, -1);
    run_frame(20'h12345, 3'b001, 0, 10, -1);
    run_frame(20'h01234, 3'b011, 1, -1, 15);
    run_frame(20'h01234, 3'b011, 0, -1, -1);
    run_frame(20'hA0000, 3'b111, 1, -1, -1);
    run_frame(20'h00000, 3'b101, 2, -1, -1);
    for (int f = 0; f < 8; f++) begin
      logic [19:0] rd;
      rd = 20'($urandom);
      if (f % 2 == 0) rd = rd >> (4 * $urandom_range(0, 4));
      run_frame(rd, 3'($urandom_range(0, 7)), 1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/digit_column_sequencer.md
DIGIT_COLUMN_SEQUENCER -- requirements
Module: digit_column_sequencer

Interface
REQ-001 Parameter NUM_DIGITS, default 5: number of BCD digits per frame; NUM_DIGITS*6 SHALL be <= MATRIX_COLS.
REQ-002 Parameter MATRIX_COLS, default 32: total columns emitted per frame, including pad columns.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 digits  input  4*NUM_DIGITS  BCD digits; MS nibble = digit 0 = leftmost.
REQ-007 color  input  3  glyph colour {B,G,R}.
REQ-008 num  output  4  digit value driven to the glyph generator.
REQ-009 numcol_index  output  3  glyph column index 0..5 driven to the generator.
REQ-010 num_color  output  3  latched colour driven to the generator.
REQ-011 gen_col  input  32  combinational column data returned by the generator.
REQ-012 col_data  output  32  registered column pixel data.
REQ-013 col_addr  output  5  registered matrix column address 0..MATRIX_COLS-1.
REQ-014 col_valid  output  1  col_data/col_addr valid.
REQ-015 col_ready  input  1  downstream accepts the column when high with col_valid.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at frame completion.

Function
REQ-018 FSM states SHALL be IDLE, EMIT, PAD, DONE.
REQ-019 IDLE: on start=1, digits and color SHALL be latched, counters cleared, next state EMIT.
REQ-020 start while busy=1 SHALL be ignored; latched digits/color SHALL NOT change mid-frame.
REQ-021 EMIT: num = latched digit[d], numcol_index = c, with d in 0..NUM_DIGITS-1 and c in 0..5.
REQ-022 Output register loads when col_valid=0 or (col_valid & col_ready): col_data=gen_col, col_addr=d*6+c, col_valid=1.
REQ-023 While col_valid=1 and col_ready=0, col_data, col_addr, num and numcol_index SHALL hold stable.
REQ-024 Throughput: one column per cycle while col_ready is held high; first col_valid SHALL rise on the 2nd rising edge after start is sampled.
REQ-025 c SHALL wrap 5->0 incrementing d; after d=NUM_DIGITS-1, c=5 is loaded, next state PAD (or DONE if NUM_DIGITS*6 = MATRIX_COLS).
REQ-026 PAD: load col_data=0 for addresses NUM_DIGITS*6..MATRIX_COLS-1 under the same handshake rule.
REQ-027 After the handshake of address MATRIX_COLS-1, col_valid SHALL fall; state DONE asserts done for exactly one cycle, then IDLE.
REQ-028 Digit values 10..15 SHALL be passed to num unchanged; the generator's glyph is forwarded unmodified.
REQ-029 num, numcol_index SHALL be 0 in IDLE and DONE; num_color SHALL hold the last latched colour.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, col_valid=0, col_data=0, col_addr=0, busy=0, done=0, counters=0, latched digits=0, num_color=0.
REQ-031 Reset mid-frame SHALL abort the frame with no done pulse; the first start after release begins a full frame at col_addr 0.

Configuration
REQ-032 Macro LEADING_ZERO_BLANK_EN defined: digits equal to 0 preceding the first nonzero digit, excluding digit NUM_DIGITS-1, SHALL emit col_data=0 for all 6 columns, with unchanged addressing and timing.
REQ-033 LEADING_ZERO_BLANK_EN undefined: every digit SHALL be rendered from gen_col; no blanking logic present.

Verification
REQ-034 digits=20'h01234, color=3'b010, col_ready=1 -> 32 beats, addr 0..31 contiguous, beat 6 = generator(1,0)&green, beats 30-31 = 0, done one cycle after beat 31.
REQ-035 Same frame, col_ready toggling 1,0,0,1 -> no beat lost or duplicated, data/addr stable while stalled, 32 beats total.
REQ-036 digits=20'h00007 with LEADING_ZERO_BLANK_EN -> beats 0..23 = 0, beats 24..29 show '7'; without macro, beats 0..23 show '0' glyphs.
REQ-037 start pulsed at beat 10 with digits=20'h99999 -> ignored, frame continues with original digits.
REQ-038 rst_n low at beat 15 -> col_valid=0 same cycle, no done; next start emits from addr 0.
REQ-039 digits=20'hA0000 -> beats 0..5 equal generator error glyph for num=10, no blanking applied.
